// File: rtl/stream_mux_arb_pkg.sv
// Shared types for the stream multiplexer: arbitration mode and lock FSM state.
package mux_pkg;

  typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_t;
  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Combinational arbiter: one-hot grant from requests, rotating pointer and lock.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int        CHANNELS = 4,
  parameter arb_mode_t MODE     = ARB_RR
) (
  input  logic [CHANNELS-1:0]         req,
  input  logic [$clog2(CHANNELS)-1:0] ptr,
  input  logic                        lock_en,
  input  logic [$clog2(CHANNELS)-1:0] lock_ch,
  output logic [CHANNELS-1:0]         grant
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    if (lock_en) begin
      // a locked channel keeps the grant even while it is idle
      grant[lock_ch] = req[lock_ch];
    end else if (MODE == ARB_FIXED) begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (req[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        idx = int'(ptr) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream mux with arbitration, packet lock and a
// single-entry registered output stage tagged with the source channel.
//
//   state    | meaning
//   UNLOCKED | arbitrate freely among valid channels
//   LOCKED   | grant held on lock_ch until its in_last beat transfers
module stream_mux_arb
  import mux_pkg::*;
#(
  parameter int        CHANNELS = 4,
  parameter int        W        = 8,
  parameter arb_mode_t MODE     = ARB_RR,
  parameter bit        LOCK     = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CHANNELS-1:0]           in_valid,
  output logic [CHANNELS-1:0]           in_ready,
  input  logic [CHANNELS*W-1:0]         in_data,
  input  logic [CHANNELS-1:0]           in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [W-1:0]                  out_data,
  output logic                          out_last,
  output logic [$clog2(CHANNELS)-1:0]   out_chan
);

  localparam int CW = $clog2(CHANNELS);

  lock_state_t         lock_state;
  logic [CW-1:0]       lock_ch;
  logic [CW-1:0]       ptr;
  logic [CW-1:0]       sel_chan;
  logic [CHANNELS-1:0] grant;
  logic [W-1:0]        sel_data;
  logic                sel_last;
  logic                load;
  logic                xfer;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .MODE     (MODE)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .lock_en (lock_state == LOCKED),
    .lock_ch (lock_ch),
    .grant   (grant)
  );

  assign load     = !out_valid || out_ready;
  assign in_ready = (rst_n && load) ? (grant & in_valid) : '0;
  assign xfer     = |in_ready;

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    sel_chan = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) begin
        sel_data = in_data[i*W +: W];
        sel_last = in_last[i];
        sel_chan = CW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_chan   <= '0;
      ptr        <= '0;
      lock_ch    <= '0;
      lock_state <= UNLOCKED;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_chan  <= sel_chan;
      // pointer keeps rotating while locked so fairness resumes after unlock
      ptr       <= (sel_chan == CW'(CHANNELS - 1)) ? '0 : sel_chan + CW'(1);
      if (LOCK) begin
        case (lock_state)
          UNLOCKED: if (!sel_last) begin
            lock_state <= LOCKED;
            lock_ch    <= sel_chan;
          end
          LOCKED:   if (sel_last) lock_state <= UNLOCKED;
          default:  lock_state <= UNLOCKED;
        endcase
      end
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Randomized + directed bench for stream_mux_arb: three configurations share
// one stimulus stream and are checked against a rule-level reference model.
module tb_stream_mux_arb;

  localparam int N = 3;  // 0: RR/no lock, 1: FIXED/no lock, 2: RR/lock

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in_valid = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_last = '0;
  logic        out_ready = 1'b0;

  logic [3:0] rdy [N];
  logic       ov  [N];
  logic [7:0] od  [N];
  logic       ol  [N];
  logic [1:0] oc  [N];

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state per instance
  bit       m_valid  [N];
  bit [7:0] m_data   [N];
  bit       m_last   [N];
  int       m_chan   [N];
  int       m_ptr    [N];
  bit       m_locked [N];
  int       m_lch    [N];

  always #5 clk = ~clk;

  stream_mux_arb #(.CHANNELS(4), .W(8), .MODE(mux_pkg::ARB_RR), .LOCK(1'b0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
    .in_last(in_last), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .out_last(ol[0]), .out_chan(oc[0]));

  stream_mux_arb #(.CHANNELS(4), .W(8), .MODE(mux_pkg::ARB_FIXED), .LOCK(1'b0)) dut_fx (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
    .in_last(in_last), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .out_last(ol[1]), .out_chan(oc[1]));

  stream_mux_arb #(.CHANNELS(4), .W(8), .MODE(mux_pkg::ARB_RR), .LOCK(1'b1)) dut_lk (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
    .in_last(in_last), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .out_last(ol[2]), .out_chan(oc[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_fixed(int i); return i == 1; endfunction
  function automatic bit lock_on(int i);  return i == 2; endfunction

  // winning channel under the arbitration rules, -1 if nobody may win
  function automatic int ref_grant(int i, logic [3:0] v);
    if (lock_on(i) && m_locked[i]) return v[m_lch[i]] ? m_lch[i] : -1;
    if (is_fixed(i)) begin
      for (int c = 0; c < 4; c++) if (v[c]) return c;
      return -1;
    end
    for (int k = 0; k < 4; k++) if (v[(m_ptr[i] + k) % 4]) return (m_ptr[i] + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_data[i] = 0; m_last[i] = 0; m_chan[i] = 0;
      m_ptr[i] = 0; m_locked[i] = 0; m_lch[i] = 0;
    end
  endtask

  task automatic check_outputs(input string sfx);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("out_valid[%0d]%s", i, sfx), 32'(ov[i]), 32'(m_valid[i]));
      chk($sformatf("out_data[%0d]%s", i, sfx), 32'(od[i]), 32'(m_data[i]));
      chk($sformatf("out_last[%0d]%s", i, sfx), 32'(ol[i]), 32'(m_last[i]));
      chk($sformatf("out_chan[%0d]%s", i, sfx), 32'(oc[i]), 32'(m_chan[i]));
    end
  endtask

  // one clock: check in_ready mid-cycle, advance model, check registered outputs
  task automatic step();
    int  g;
    bit  load;
    @(negedge clk); #1;
    for (int i = 0; i < N; i++) begin
      g    = ref_grant(i, in_valid);
      load = !m_valid[i] || out_ready;
      chk($sformatf("in_ready[%0d]", i), 32'(rdy[i]), (load && g >= 0) ? (32'd1 << g) : 32'd0);
      if (load && g >= 0) begin
        m_valid[i] = 1;
        m_data[i]  = in_data[g*8 +: 8];
        m_last[i]  = in_last[g];
        m_chan[i]  = g;
        m_ptr[i]   = (g + 1) % 4;
        if (lock_on(i)) begin
          if (!m_locked[i] && !in_last[g]) begin
            m_locked[i] = 1;
            m_lch[i]    = g;
          end else if (m_locked[i] && in_last[g]) begin
            m_locked[i] = 0;
          end
        end
      end else if (load) begin
        m_valid[i] = 0;
      end
    end
    @(posedge clk); #1;
    check_outputs("");
  endtask

  // called between steps (posedge+1); asserts reset away from any edge
  task automatic do_reset();
    #3;
    in_valid = 4'hF;
    rst_n    = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst out_valid[%0d]", i), 32'(ov[i]), 32'd0);
      chk($sformatf("rst out_chan[%0d]", i), 32'(oc[i]), 32'd0);
      chk($sformatf("rst in_ready[%0d]", i), 32'(rdy[i]), 32'd0);
    end
    in_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs(" after reset");
  endtask

  initial begin
    int rr_seq [5] = '{0, 1, 2, 3, 0};
    int wrap_seq [3] = '{3, 0, 3};

    do_reset();

    // round-robin fairness, then wrap with only ch3/ch0 requesting
    in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = $urandom;
      step();
      chk($sformatf("rr chan %0d", k), 32'(oc[0]), 32'(rr_seq[k]));
    end
    step(); step();
    in_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      in_data = $urandom;
      step();
      chk($sformatf("wrap chan %0d", k), 32'(oc[0]), 32'(wrap_seq[k]));
    end

    // fixed priority: ch1 beats ch3 until ch1 drops
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      in_data = $urandom;
      step();
      chk("fixed ch1", 32'(oc[1]), 32'd1);
    end
    in_valid = 4'b1000;
    step();
    chk("fixed ch3", 32'(oc[1]), 32'd3);

    // backpressure
    in_valid = 4'b0001; in_data = 32'h000000A5;
    step();
    chk("bp capture", 32'(od[0]), 32'hA5);
    out_ready = 1'b0; in_valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      in_data = $urandom;
      step();
      chk("bp hold data", 32'(od[0]), 32'hA5);
      chk("bp in_ready", 32'(rdy[0]), 32'd0);
    end
    out_ready = 1'b1; in_data = 32'h3C3C3C3C;
    step();
    chk("bp next word", 32'(od[0]), 32'h3C);

    // packet lock on ch2 with ch0 waiting
    do_reset();
    in_valid = 4'b0010; in_last = 4'hF;
    step();
    in_valid = 4'b0101; in_last = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      in_data = $urandom;
      step();
      chk("lock beat", 32'(oc[2]), 32'd2);
    end
    in_valid = 4'b0001;
    step();
    chk("lock gap valid", 32'(ov[2]), 32'd0);
    in_valid = 4'b0101; in_last = 4'b0100; in_data = $urandom;
    step();
    chk("lock last beat", 32'(oc[2]), 32'd2);
    in_valid = 4'b0001; in_last = 4'b0000;
    step();
    chk("after unlock", 32'(oc[2]), 32'd0);

    // randomized traffic with a reset in the middle
    for (int n = 0; n < 500; n++) begin
      if (n == 250) do_reset();
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = $urandom;
      for (int c = 0; c < 4; c++) in_last[c] = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
